// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter
//   Two-master AXI-lite arbiter in front of one sram_axi slave port.
//   Master 0 is the uart_debug port. Master 1 is reserved for a core or video port.
//   Only one transaction, read or write, is in flight at a time.
//   Masters are granted round-robin.
//
// Build option:
//   ARB_FIXED_PRIO_EN - when defined, master 0 always wins a tie and master 1
//                       may starve. When undefined, ties alternate round-robin.
//
// Ports:
//   clk, reset_            system clock, asynchronous active-low reset
//   mN_ar_* / mN_r_*       master N read address / read response (N = 0, 1)
//   mN_aw_* / mN_w_*       master N write address / write data
//   mN_b_*                 master N write response
//   s_*                    slave side, connects to sram_axi
//   grant                  one-hot owner of the current transaction, 0 in IDLE
//   busy                   high in every state except IDLE
//
// state | meaning
// IDLE  | arbitrate; latch the owner on the clock edge
// AR    | forward the owner's read address
// R     | forward the read response to the owner
// WR    | forward AW and W independently until both have handshaken
// B     | forward the write response to the owner
module sram_axi_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic [ADDR_W-1:0]   m0_ar_addr,
  input  logic                m0_ar_valid,
  output logic                m0_ar_ready,
  output logic [DATA_W-1:0]   m0_r_data,
  output logic [1:0]          m0_r_resp,
  output logic                m0_r_valid,
  input  logic                m0_r_ready,
  input  logic [ADDR_W-1:0]   m0_aw_addr,
  input  logic                m0_aw_valid,
  output logic                m0_aw_ready,
  input  logic [DATA_W-1:0]   m0_w_data,
  input  logic [DATA_W/8-1:0] m0_w_strb,
  input  logic                m0_w_valid,
  output logic                m0_w_ready,
  output logic [1:0]          m0_b_resp,
  output logic                m0_b_valid,
  input  logic                m0_b_ready,
  input  logic [ADDR_W-1:0]   m1_ar_addr,
  input  logic                m1_ar_valid,
  output logic                m1_ar_ready,
  output logic [DATA_W-1:0]   m1_r_data,
  output logic [1:0]          m1_r_resp,
  output logic                m1_r_valid,
  input  logic                m1_r_ready,
  input  logic [ADDR_W-1:0]   m1_aw_addr,
  input  logic                m1_aw_valid,
  output logic                m1_aw_ready,
  input  logic [DATA_W-1:0]   m1_w_data,
  input  logic [DATA_W/8-1:0] m1_w_strb,
  input  logic                m1_w_valid,
  output logic                m1_w_ready,
  output logic [1:0]          m1_b_resp,
  output logic                m1_b_valid,
  input  logic                m1_b_ready,
  output logic [ADDR_W-1:0]   s_ar_addr,
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_valid,
  output logic                s_r_ready,
  output logic [ADDR_W-1:0]   s_aw_addr,
  output logic                s_aw_valid,
  input  logic                s_aw_ready,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  output logic                s_w_valid,
  input  logic                s_w_ready,
  input  logic [1:0]          s_b_resp,
  input  logic                s_b_valid,
  output logic                s_b_ready,
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = master 0, 1 = master 1
  logic        last_q, last_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;

  logic req0, req1, pick;
  logic in_ar, in_r, in_wr, in_b, active, own0, own1;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic [ADDR_W-1:0]   g_ar_addr, g_aw_addr;
  logic [DATA_W-1:0]   g_w_data;
  logic [DATA_W/8-1:0] g_w_strb;
  logic                g_ar_valid, g_aw_valid, g_w_valid, g_r_ready, g_b_ready;

  assign req0 = m0_ar_valid | (m0_aw_valid & m0_w_valid);
  assign req1 = m1_ar_valid | (m1_aw_valid & m1_w_valid);

`ifdef ARB_FIXED_PRIO_EN
  // Master 1 is only picked when master 0 is not requesting.
  assign pick = ~req0;
`else
  assign pick = (req0 & req1) ? ~last_q : req1;
`endif

  always_comb begin
    g_ar_addr  = owner_q ? m1_ar_addr  : m0_ar_addr;
    g_ar_valid = owner_q ? m1_ar_valid : m0_ar_valid;
    g_aw_addr  = owner_q ? m1_aw_addr  : m0_aw_addr;
    g_aw_valid = owner_q ? m1_aw_valid : m0_aw_valid;
    g_w_data   = owner_q ? m1_w_data   : m0_w_data;
    g_w_strb   = owner_q ? m1_w_strb   : m0_w_strb;
    g_w_valid  = owner_q ? m1_w_valid  : m0_w_valid;
    g_r_ready  = owner_q ? m1_r_ready  : m0_r_ready;
    g_b_ready  = owner_q ? m1_b_ready  : m0_b_ready;
  end

  assign in_ar  = (state_q == S_AR);
  assign in_r   = (state_q == S_R);
  assign in_wr  = (state_q == S_WR);
  assign in_b   = (state_q == S_B);
  assign active = (state_q != S_IDLE);
  assign own0   = ~owner_q;
  assign own1   = owner_q;

  // Slave side. Valids and readies come only from state and owner, so IDLE
  // has no valid-to-ready path.
  assign s_ar_addr  = active ? g_ar_addr : '0;
  assign s_aw_addr  = active ? g_aw_addr : '0;
  assign s_w_data   = active ? g_w_data  : '0;
  assign s_w_strb   = active ? g_w_strb  : '0;
  assign s_ar_valid = in_ar & g_ar_valid;
  assign s_aw_valid = in_wr & ~aw_done_q & g_aw_valid;
  assign s_w_valid  = in_wr & ~w_done_q & g_w_valid;
  assign s_r_ready  = in_r & g_r_ready;
  assign s_b_ready  = in_b & g_b_ready;

  assign ar_hs = s_ar_valid & s_ar_ready;
  assign r_hs  = s_r_valid & s_r_ready;
  assign aw_hs = s_aw_valid & s_aw_ready;
  assign w_hs  = s_w_valid & s_w_ready;
  assign b_hs  = s_b_valid & s_b_ready;

  // Master side. Readies are masked once a channel is done, so the master
  // never sees a second handshake on the same channel.
  assign m0_ar_ready = in_ar & own0 & s_ar_ready;
  assign m0_r_valid  = in_r & own0 & s_r_valid;
  assign m0_r_data   = (in_r & own0) ? s_r_data : '0;
  assign m0_r_resp   = (in_r & own0) ? s_r_resp : '0;
  assign m0_aw_ready = in_wr & own0 & ~aw_done_q & s_aw_ready;
  assign m0_w_ready  = in_wr & own0 & ~w_done_q & s_w_ready;
  assign m0_b_valid  = in_b & own0 & s_b_valid;
  assign m0_b_resp   = (in_b & own0) ? s_b_resp : '0;

  assign m1_ar_ready = in_ar & own1 & s_ar_ready;
  assign m1_r_valid  = in_r & own1 & s_r_valid;
  assign m1_r_data   = (in_r & own1) ? s_r_data : '0;
  assign m1_r_resp   = (in_r & own1) ? s_r_resp : '0;
  assign m1_aw_ready = in_wr & own1 & ~aw_done_q & s_aw_ready;
  assign m1_w_ready  = in_wr & own1 & ~w_done_q & s_w_ready;
  assign m1_b_valid  = in_b & own1 & s_b_valid;
  assign m1_b_resp   = (in_b & own1) ? s_b_resp : '0;

  assign grant = grant_q;
  assign busy  = busy_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_d   = pick;
          grant_d   = pick ? 2'b10 : 2'b01;
          busy_d    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // A pending read from the chosen master goes ahead of its write.
          state_d   = (pick ? m1_ar_valid : m0_ar_valid) ? S_AR : S_WR;
        end
      end
      S_AR: if (ar_hs) state_d = S_R;
      S_R: begin
        if (r_hs) begin
          state_d = S_IDLE;
          last_d  = owner_q;
          grant_d = 2'b00;
          busy_d  = 1'b0;
        end
      end
      S_WR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d & w_done_d) state_d = S_B;
      end
      S_B: begin
        if (b_hs) begin
          state_d = S_IDLE;
          last_d  = owner_q;
          grant_d = 2'b00;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
module tb_sram_axi_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int STRB_W = DATA_W / 8;

  logic clk, reset_;
  logic [ADDR_W-1:0] m0_ar_addr, m1_ar_addr, m0_aw_addr, m1_aw_addr;
  logic m0_ar_valid, m1_ar_valid, m0_aw_valid, m1_aw_valid, m0_w_valid, m1_w_valid;
  logic m0_r_ready, m1_r_ready, m0_b_ready, m1_b_ready;
  logic [DATA_W-1:0] m0_w_data, m1_w_data;
  logic [STRB_W-1:0] m0_w_strb, m1_w_strb;
  logic m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, m0_aw_ready, m1_aw_ready;
  logic m0_w_ready, m1_w_ready, m0_b_valid, m1_b_valid;
  logic [DATA_W-1:0] m0_r_data, m1_r_data;
  logic [1:0] m0_r_resp, m1_r_resp, m0_b_resp, m1_b_resp;
  logic [ADDR_W-1:0] s_ar_addr, s_aw_addr;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_aw_valid, s_aw_ready;
  logic s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [DATA_W-1:0] s_r_data, s_w_data;
  logic [STRB_W-1:0] s_w_strb;
  logic [1:0] s_r_resp, s_b_resp, grant;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  sram_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_(reset_),
    .m0_ar_addr(m0_ar_addr), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m0_aw_addr(m0_aw_addr), .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
    .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
    .m0_b_resp(m0_b_resp), .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
    .m1_ar_addr(m1_ar_addr), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .m1_aw_addr(m1_aw_addr), .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
    .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
    .m1_b_resp(m1_b_resp), .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .grant(grant), .busy(busy)
  );

  wire [24:0] m0_out = {m0_ar_ready, m0_r_data, m0_r_resp, m0_r_valid,
                        m0_aw_ready, m0_w_ready, m0_b_resp, m0_b_valid};
  wire [24:0] m1_out = {m1_ar_ready, m1_r_data, m1_r_resp, m1_r_valid,
                        m1_aw_ready, m1_w_ready, m1_b_resp, m1_b_valid};
  wire [58:0] s_out  = {s_ar_addr, s_ar_valid, s_r_ready, s_aw_addr, s_aw_valid,
                        s_w_data, s_w_strb, s_w_valid, s_b_ready};
  wire [111:0] all_out = {m0_out, m1_out, s_out, grant, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one read by master m, assuming the arbiter is in IDLE and will pick m.
  task automatic serve_read(input int m, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = a[DATA_W-1:0];
    step();
    chk("rd_grant", grant, (m == 1) ? 2'b10 : 2'b01);
    chk("rd_s_ar_valid", s_ar_valid, 1'b1);
    chk("rd_s_ar_addr", s_ar_addr, a);
    chk("rd_ar_ready", (m == 1) ? m1_ar_ready : m0_ar_ready, 1'b1);
    step();
    if (m == 1) m1_ar_valid = 1'b0; else m0_ar_valid = 1'b0;
    s_r_valid = 1'b1; s_r_data = d; s_r_resp = 2'b00;
    #1;
    chk("rd_r_valid", (m == 1) ? m1_r_valid : m0_r_valid, 1'b1);
    chk("rd_r_data", (m == 1) ? m1_r_data : m0_r_data, d);
    chk("rd_r_resp", (m == 1) ? m1_r_resp : m0_r_resp, 2'b00);
    chk("rd_other_out", (m == 1) ? m0_out : m1_out, 25'd0);
    step();
    s_r_valid = 1'b0; s_r_data = '0;
    #1;
    chk("rd_done_busy", busy, 1'b0);
  endtask

  initial begin
    reset_ = 1'b0;
    m0_ar_addr = '0; m1_ar_addr = '0; m0_aw_addr = '0; m1_aw_addr = '0;
    m0_ar_valid = 0; m1_ar_valid = 0; m0_aw_valid = 0; m1_aw_valid = 0;
    m0_w_valid = 0; m1_w_valid = 0; m0_w_data = '0; m1_w_data = '0;
    m0_w_strb = '0; m1_w_strb = '0;
    m0_r_ready = 1; m1_r_ready = 1; m0_b_ready = 1; m1_b_ready = 1;
    s_ar_ready = 1; s_r_data = '0; s_r_resp = '0; s_r_valid = 0;
    s_aw_ready = 0; s_w_ready = 0; s_b_resp = '0; s_b_valid = 0;
    #2;
    chk("reset_all_zero", all_out, 112'd0);
    step();
    reset_ = 1'b1;

    // 1: single read, address-echo slave
    m0_ar_addr = 18'h37648; m0_ar_valid = 1'b1;
    #1;
    chk("t1_idle_no_valid", s_ar_valid, 1'b0);
    chk("t1_idle_no_ready", m0_ar_ready, 1'b0);
    serve_read(0, 18'h37648);
    chk("t1_m1_quiet", m1_out, 25'd0);

    // 2: round-robin reads; reset first so master 0 is due
    reset_ = 1'b0; #1; reset_ = 1'b1;
    m0_ar_addr = 18'h00000; m0_ar_valid = 1'b1;
    m1_ar_addr = 18'h3ffff; m1_ar_valid = 1'b1;
    serve_read(0, 18'h00000);
    m0_ar_addr = 18'h00123; m0_ar_valid = 1'b1;
    serve_read(1, 18'h3ffff);
    serve_read(0, 18'h00123);

    // 3: split write, W arrives 3 cycles after AW, AW ready delayed
    m0_aw_addr = 18'h1aa55; m0_aw_valid = 1'b1;
    m0_w_data = 16'hbeef; m0_w_strb = 2'b11;
    repeat (3) begin
      step();
      chk("t3_aw_only_no_grant", busy, 1'b0);
    end
    m0_w_valid = 1'b1;
    step();
    chk("t3_grant", grant, 2'b01);
    chk("t3_s_aw_valid", s_aw_valid, 1'b1);
    chk("t3_s_aw_addr", s_aw_addr, 18'h1aa55);
    chk("t3_s_w_data", {s_w_valid, s_w_strb, s_w_data}, {1'b1, 2'b11, 16'hbeef});
    chk("t3_aw_ready_held", m0_aw_ready, 1'b0);
    step();
    s_aw_ready = 1'b1;
    #1;
    chk("t3_aw_ready", m0_aw_ready, 1'b1);
    chk("t3_w_ready_low", m0_w_ready, 1'b0);
    step();
    m0_aw_valid = 1'b0;
    #1;
    chk("t3_aw_masked", s_aw_valid, 1'b0);
    chk("t3_w_pending", s_w_valid, 1'b1);
    chk("t3_not_in_b", s_b_ready, 1'b0);
    chk("t3_grant_wr", grant, 2'b01);
    s_w_ready = 1'b1;
    #1;
    chk("t3_w_ready", m0_w_ready, 1'b1);
    chk("t3_aw_ready_masked", m0_aw_ready, 1'b0);
    step();
    m0_w_valid = 1'b0; s_w_ready = 1'b0; s_aw_ready = 1'b0;
    s_b_valid = 1'b1; s_b_resp = 2'b00;
    #1;
    chk("t3_b_ready", s_b_ready, 1'b1);
    chk("t3_b_valid", {m0_b_valid, m0_b_resp}, {1'b1, 2'b00});
    chk("t3_m1_b_quiet", m1_b_valid, 1'b0);
    chk("t3_grant_b", grant, 2'b01);
    chk("t3_w_masked", s_w_valid, 1'b0);
    step();
    s_b_valid = 1'b0;
    #1;
    chk("t3_done_busy", busy, 1'b0);

    // 4: read and write both pending on master 0; the read goes first
    m0_ar_addr = 18'h00abc; m0_ar_valid = 1'b1;
    m0_aw_addr = 18'h12345; m0_aw_valid = 1'b1;
    m0_w_data = 16'h5a5a; m0_w_valid = 1'b1;
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    serve_read(0, 18'h00abc);
    step();
    chk("t4_wr_grant", grant, 2'b01);
    chk("t4_wr_aw", {s_aw_valid, s_aw_addr}, {1'b1, 18'h12345});
    chk("t4_wr_no_ar", s_ar_valid, 1'b0);
    step();
    m0_aw_valid = 1'b0; m0_w_valid = 1'b0;
    s_aw_ready = 1'b0; s_w_ready = 1'b0;
    s_b_valid = 1'b1;
    #1;
    chk("t4_b_valid", m0_b_valid, 1'b1);
    step();
    s_b_valid = 1'b0;
    #1;
    chk("t4_done_busy", busy, 1'b0);

    // 5: master 1 stalls its read response for 5 cycles
    m1_ar_addr = 18'h20abc; m1_ar_valid = 1'b1; m1_r_ready = 1'b0;
    step();
    chk("t5_grant_m1", grant, 2'b10);
    step();
    m1_ar_valid = 1'b0;
    s_r_valid = 1'b1; s_r_data = 16'h0abc;
    m0_ar_addr = 18'h01111; m0_ar_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_s_r_ready_low", s_r_ready, 1'b0);
      chk("t5_grant_held", grant, 2'b10);
      chk("t5_m1_r_data", {m1_r_valid, m1_r_data}, {1'b1, 16'h0abc});
      chk("t5_m0_blocked", m0_ar_ready, 1'b0);
      step();
    end
    m1_r_ready = 1'b1;
    #1;
    chk("t5_s_r_ready", s_r_ready, 1'b1);
    step();
    s_r_valid = 1'b0; s_r_data = '0;
    #1;
    chk("t5_idle_after_r", {grant, busy}, 3'b000);
    step();
    chk("t5_m0_granted", grant, 2'b01);
    chk("t5_m0_addr", s_ar_addr, 18'h01111);

    // 6: reset in the middle of a read, both masters requesting
    m1_ar_addr = 18'h3ffff; m1_ar_valid = 1'b1;
    step();
    s_r_valid = 1'b1; s_r_data = 16'h1111;
    #1;
    chk("t6_in_r", m0_r_valid, 1'b1);
    reset_ = 1'b0;
    #1;
    chk("t6_async_zero", all_out, 112'd0);
    s_r_valid = 1'b0; s_r_data = '0;
    step();
    chk("t6_held_zero", all_out, 112'd0);
    reset_ = 1'b1;
    #1;
    chk("t6_release_idle", busy, 1'b0);
    step();
    chk("t6_m0_wins", grant, 2'b01);
    chk("t6_m0_ar", {s_ar_valid, s_ar_addr}, {1'b1, 18'h01111});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
